// File: rtl/dht11_apb_ctrl.sv
// APB-controlled acquisition sequencer for a DHT11 sensor controller.
// Issues start pulses manually or periodically and latches the sensor result.
module dht11_apb_ctrl #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int ACQ_MS     = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        dht_start,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature
);

    localparam int CLKS_PER_MS = SYS_CLK_HZ / 1000;
    localparam int PRE_W       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [15:0]      ACQ_LAST   = 16'(ACQ_MS - 1);
    localparam logic [15:0]      PERIOD_RST = 16'd2000;
    localparam logic [15:0]      PERIOD_MIN = 16'd1000;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRIG    = 2'd1;
    localparam logic [1:0] ACQ     = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      ms_cnt;
    logic [15:0]      auto_tmr;
    logic             auto_en;
    logic [15:0]      period;
    logic             valid;
    logic             overrun;
    logic [31:0]      data;

    logic        apb_wr;
    logic [1:0]  reg_sel;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_status;
    logic        start_wr;
    logic        auto_rise;
    logic        ms_tick;
    logic [15:0] eff_period;
    logic        auto_expire;
    logic        start_req;
    logic        busy;
    logic        trig_accept;
    logic        overrun_set;
    logic        capture;
    logic [31:0] rd_mux;

    // APB handshake: PREADY is tied high, so a transfer completes in the single
    // cycle where PSEL and PENABLE are both 1; the setup cycle has no side effects.
    assign PREADY    = 1'b1;
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign reg_sel   = PADDR[3:2];
    assign wr_ctrl   = apb_wr & (reg_sel == 2'd0);
    assign wr_period = apb_wr & (reg_sel == 2'd1);
    assign wr_status = apb_wr & (reg_sel == 2'd2);

    assign start_wr  = wr_ctrl & PWDATA[0];
    assign auto_rise = wr_ctrl & PWDATA[1] & ~auto_en;

    assign ms_tick    = (pre_cnt == PRE_LAST);
    assign eff_period = (period < PERIOD_MIN) ? PERIOD_MIN : period;
    // Fires on the tick that would bring the timer up to the effective period.
    assign auto_expire = auto_en & ms_tick &
                         (({1'b0, auto_tmr} + 17'd1) >= {1'b0, eff_period});

    // A manual start and an auto expiry in one cycle merge into one request.
    assign start_req   = start_wr | auto_expire;
    assign busy        = (state != IDLE);
    assign trig_accept = start_req & ~busy;
    assign overrun_set = start_req & busy;
    assign capture     = (state == CAPTURE);
    assign dht_start   = (state == TRIG);

    wire unused_ok = &{1'b0, PADDR[1:0], PWDATA[31:16]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig_accept) state_nxt = TRIG;
            TRIG:    state_nxt = ACQ;
            ACQ:     if (ms_tick && (ms_cnt == ACQ_LAST)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The prescaler free-runs for the auto timer but is realigned at TRIG so the
    // acquisition window is an exact number of ms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            if ((state == TRIG) || ms_tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (state == TRIG) begin
                ms_cnt <= '0;
            end else if ((state == ACQ) && ms_tick) begin
                ms_cnt <= ms_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_tmr <= '0;
        end else if (!auto_en || auto_rise || trig_accept || auto_expire) begin
            auto_tmr <= '0;
        end else if (ms_tick) begin
            auto_tmr <= auto_tmr + 16'd1;
        end
    end

    // Status set events take priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_en <= 1'b0;
            period  <= PERIOD_RST;
            valid   <= 1'b0;
            overrun <= 1'b0;
            data    <= '0;
        end else begin
            if (wr_ctrl) begin
                auto_en <= PWDATA[1];
            end
            if (wr_period) begin
                period <= PWDATA[15:0];
            end
            if (capture) begin
                valid <= 1'b1;
            end else if (wr_status && PWDATA[1]) begin
                valid <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (wr_status && PWDATA[2]) begin
                overrun <= 1'b0;
            end
            if (capture) begin
                data <= {humidity, temperature};
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux = {30'd0, auto_en, 1'b0};
            2'd1:    rd_mux = {16'd0, period};
            2'd2:    rd_mux = {29'd0, overrun, valid, busy};
            2'd3:    rd_mux = data;
            default: rd_mux = '0;
        endcase
        PRDATA = PSEL ? rd_mux : 32'd0;
    end

endmodule

// File: tb/tb_dht11_apb_ctrl.sv
// Directed bench for dht11_apb_ctrl: APB reads are scored by a negedge monitor
// against an expected queue; start pulses are timestamped by the same monitor.
module tb_dht11_apb_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        dht_start;
    logic [15:0] humidity;
    logic [15:0] temperature;

    dht11_apb_ctrl #(.SYS_CLK_HZ(1000), .ACQ_MS(25)) dut (
        .clk         (clk),
        .rst         (rst),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .dht_start   (dht_start),
        .humidity    (humidity),
        .temperature (temperature)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          pulse_cyc[$];
    bit          prev_start = 1'b0;
    int          width      = 0;
    logic [31:0] mon_exp;
    string       mon_name;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // monitor: scores completed reads and timestamps start pulses
    always @(negedge clk) begin
        if (!rst && PSEL && PENABLE && !PWRITE) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read addr=0x%0h actual=0x%08h required=none", PADDR, PRDATA);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (PRDATA !== mon_exp || PREADY !== 1'b1) begin
                    failures++;
                    $display("FAIL %s actual=0x%08h pready=%0b required=0x%08h pready=1",
                             mon_name, PRDATA, PREADY, mon_exp);
                end
            end
        end
        if (dht_start && !prev_start) begin
            pulse_cyc.push_back(cyc);
            width = 1;
        end else if (dht_start) begin
            width++;
        end
        if (!dht_start && prev_start) begin
            checks++;
            if (width != 1) begin
                failures++;
                $display("FAIL pulse_width actual=%0d required=1", width);
            end
        end
        prev_start = dht_start;
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int n, input int budget);
        int k = 0;
        while (pulse_cyc.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (pulse_cyc.size() < n) begin
            failures++;
            $display("FAIL wait_pulse actual=%0d required=%0d", pulse_cyc.size(), n);
        end
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulse_cyc.size()) ? pulse_cyc[i] : -1;
    endfunction

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata, output int acc);
        @(posedge clk);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // stimulus
    initial begin
        int acc;
        int t0;
        int base;
        int p1;
        int p2;
        rst = 1'b1;
        PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        humidity = '0; temperature = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state, no spontaneous trigger
        apb_read(4'h0, 32'h0, "reset_ctrl");
        apb_read(4'h4, 32'h7D0, "reset_period");
        apb_read(4'h8, 32'h0, "reset_status");
        apb_read(4'hC, 32'h0, "reset_data");
        wait_until(cyc + 50);
        check("no_pulse_after_reset", pulse_cyc.size(), 0);

        // manual start
        humidity = 16'h3700; temperature = 16'h1A05;
        apb_write(4'h0, 32'h1, acc);
        t0 = acc + 1;
        apb_read(4'h8, 32'h1, "status_busy_acq");
        check("manual_pulse_count", pulse_cyc.size(), 1);
        check("manual_pulse_cycle", pulse_at(0), t0);
        apb_read(4'hC, 32'h0, "data_before_capture");
        wait_until(t0 + 26);
        apb_read(4'h8, 32'h2, "status_valid_done");
        apb_read(4'hC, 32'h37001A05, "data_captured");
        humidity = 16'hFFFF; temperature = 16'h0000;
        apb_read(4'hC, 32'h37001A05, "data_held");
        apb_read(4'h0, 32'h0, "ctrl_start_reads0");

        // APB edge cases: unselected read, setup-only write
        PADDR = 4'hC; PSEL = 1'b0;
        #1;
        check("prdata_psel0", PRDATA, 32'h0);
        @(posedge clk);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h1234;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PWRITE = 1'b0;
        apb_read(4'h4, 32'h7D0, "setup_only_write");

        // overrun
        apb_write(4'h8, 32'h2, acc);
        apb_write(4'h0, 32'h1, acc);
        t0 = acc + 1;
        wait_until(t0 + 2);
        apb_write(4'h0, 32'h1, acc);
        apb_read(4'h8, 32'h5, "status_overrun_busy");
        wait_until(t0 + 27);
        apb_read(4'h8, 32'h6, "status_overrun_done");
        check("overrun_single_pulse", pulse_cyc.size(), 2);
        apb_write(4'h8, 32'h4, acc);
        apb_read(4'h8, 32'h2, "overrun_cleared");
        apb_write(4'h8, 32'h2, acc);
        apb_read(4'h8, 32'h0, "valid_cleared");

        // auto mode with period clamp
        apb_write(4'h4, 32'd10, acc);
        apb_read(4'h4, 32'd10, "period_readback");
        base = pulse_cyc.size();
        apb_write(4'h0, 32'h2, acc);
        wait_pulse(base + 1, 1100);
        p1 = pulse_at(base);
        wait_until(p1 + 30);
        apb_write(4'h8, 32'h2, acc);
        wait_pulse(base + 2, 1100);
        p2 = pulse_at(base + 1);
        check("auto_spacing", p2 - p1, 1000);

        // VALID clear landing on the CAPTURE cycle
        wait_until(p2 + 24);
        apb_write(4'h8, 32'h2, acc);
        check("w1c_on_capture_cycle", acc, p2 + 26);
        apb_read(4'h8, 32'h2, "valid_set_wins");

        // START write coinciding with auto expiry
        wait_until(p2 + 997);
        apb_write(4'h0, 32'h3, acc);
        apb_read(4'h8, 32'h3, "status_collision");
        apb_write(4'h8, 32'h2, acc);
        apb_write(4'h0, 32'h0, acc);
        check("collision_pulse_count", pulse_cyc.size(), base + 3);
        check("collision_pulse_cycle", pulse_at(base + 2), p2 + 1000);
        wait_until(p2 + 1035);
        apb_read(4'h8, 32'h2, "auto_off_acq_completes");
        apb_read(4'h0, 32'h0, "ctrl_auto_off");
        wait_until(cyc + 2100);
        check("no_auto_after_off", pulse_cyc.size(), base + 3);

        // reset mid-acquisition
        humidity = 16'h1234; temperature = 16'h5678;
        apb_write(4'h0, 32'h1, acc);
        t0 = acc + 1;
        wait_until(t0 + 10);
        rst = 1'b1; PSEL = 1'b1; PADDR = 4'h8;
        #1;
        check("rst_dht_start", dht_start, 1'b0);
        check("rst_status", PRDATA, 32'h0);
        PADDR = 4'hC;
        #1;
        check("rst_data", PRDATA, 32'h0);
        PADDR = 4'h4;
        #1;
        check("rst_period", PRDATA, 32'h7D0);
        PSEL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = pulse_cyc.size();
        wait_until(cyc + 100);
        check("no_pulse_after_rst", pulse_cyc.size(), base);
        apb_read(4'h8, 32'h0, "status_after_rst");
        apb_read(4'hC, 32'h0, "data_after_rst");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
